// File: rtl/pcs_tx.sv
// 100BASE-X PCS transmit: MII nibble to 4B/5B code group with /J/K/, /T/R/ framing and /I/ fill.
// One group per ce, registered (1 clk); no backpressure. Define PCS_TX_ERR_EN to send /H/ on TX_ER.
module pcs_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       enable,
  input  logic       err,
  input  logic [3:0] data,
  input  logic       link_status,
  output logic [4:0] code,
  output logic       code_ce,
  output logic       transmitting
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam logic [4:0] C_I = 5'b11111;
  localparam logic [4:0] C_J = 5'b11000;
  localparam logic [4:0] C_K = 5'b10001;
  localparam logic [4:0] C_T = 5'b01101;
  localparam logic [4:0] C_R = 5'b00111;
  localparam logic [4:0] C_H = 5'b00100;

`ifdef PCS_TX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] grp;
    case (nib)
      4'h0: grp = 5'b11110;
      4'h1: grp = 5'b01001;
      4'h2: grp = 5'b10100;
      4'h3: grp = 5'b10101;
      4'h4: grp = 5'b01010;
      4'h5: grp = 5'b01011;
      4'h6: grp = 5'b01110;
      4'h7: grp = 5'b01111;
      4'h8: grp = 5'b10010;
      4'h9: grp = 5'b10011;
      4'hA: grp = 5'b10110;
      4'hB: grp = 5'b10111;
      4'hC: grp = 5'b11010;
      4'hD: grp = 5'b11011;
      4'hE: grp = 5'b11100;
      default: grp = 5'b11101;
    endcase
    return grp;
  endfunction

  state_t     state;
  logic       err_hit;
  logic [4:0] data_grp;

  // With the feature compiled out err is folded away to a constant zero.
  assign err_hit  = ERR_EN & err;
  assign data_grp = err_hit ? C_H : enc_4b5b(data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      code         <= C_I;
      code_ce      <= 1'b0;
      transmitting <= 1'b0;
    end else begin
      code_ce <= ce;
      if (ce) begin
        if (!link_status) begin
          // Link loss abandons the packet outright: no /T/R/ is sent.
          state        <= S_IDLE;
          code         <= C_I;
          transmitting <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              if (enable) begin
                state        <= S_START;
                code         <= C_J;
                transmitting <= 1'b1;
              end else begin
                code         <= C_I;
                transmitting <= 1'b0;
              end
            end
            S_START: begin
              state        <= S_DATA;
              code         <= C_K;
              transmitting <= 1'b1;
            end
            S_DATA: begin
              transmitting <= 1'b1;
              if (enable) begin
                code <= data_grp;
              end else begin
                state <= S_END;
                code  <= C_T;
              end
            end
            S_END: begin
              state        <= S_IDLE;
              code         <= C_R;
              transmitting <= 1'b1;
            end
            default: begin
              state        <= S_IDLE;
              code         <= C_I;
              transmitting <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/pcs_tx.md
# pcs_tx

Transmit half of the 100BASE-X PCS, directly downstream of the MII transmit I/O stage. Consumes the sampled MII nibble stream (one nibble per `ce` pulse, nominally 1 in 5 clocks) and produces one 5-bit 4B/5B code group per pulse. Frames each packet with /J/K/ and /T/R/ delimiters and fills idle time with /I/. Output feeds the PMA serializer/NRZI stage.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock (125 MHz), sole clock
- `rst_n`  in  1  synchronous reset, active low
- `ce`  in  1  nibble strobe from the MII TX I/O stage; `enable`/`err`/`data` valid while high
- `enable`  in  1  TX_EN as sampled, already gated by isolate
- `err`  in  1  TX_ER as sampled
- `data`  in  4  TXD nibble as sampled
- `link_status`  in  1  1 = link up; 0 forces idle
- `code`  out  5  current code group; `code[4]` sent first
- `code_ce`  out  1  one-clock pulse, `code` updated
- `transmitting`  out  1  high from /J/ through /R/ inclusive (feeds CRS)

Reset is synchronous and active-low: `rst_n` low on a rising `clk` edge resets the block; no asynchronous path.

## Operation
- Code groups (code[4:0]): data 0–F = 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101; I=11111, J=11000, K=10001, T=01101, R=00111, H=00100.
- FSM advances only on clocks with `ce`=1; on other clocks state and outputs hold, except `code_ce` returns to 0.
- IDLE: `enable`=0 → emit I, stay. `enable`=1 → emit J, go START.
- START: emit K (nibble discarded, `enable`/`err` ignored), go DATA.
- DATA: `enable`=1 → emit encoding of `data` (or H, see Configuration), stay. `enable`=0 → emit T, go END.
- END: emit R, go IDLE regardless of `enable`; a packet whose TX_EN rises during R starts at next `ce` (one nibble lost; legal IPG forbids this).
- `err` in IDLE/START/END ignored.
- `link_status`=0 on a `ce` clock: emit I, go IDLE from any state (no T/R). `link_status` sampled only on `ce` clocks.
- `transmitting`=1 when emitted group is J, K, data, H, T or R; 0 when I.

## Timing
- Reset values: `code`=11111, `code_ce`=0, `transmitting`=0, state IDLE.
- Latency: `code`, `code_ce`, `transmitting` registered; change on the clock edge after the `ce`-high edge (1 clk).
- `code_ce` high exactly one clock per `ce` pulse; back-to-back `ce` (every clock) must be supported with one group per clock.
- First data group appears on the third `ce` after `enable` rises (J, K, then data).
- T appears on the first `ce` with `enable`=0; R on the next; I thereafter.
- Reset mid-packet: next `ce` emits I or J per `enable`; no T/R.

## Configuration
- `PCS_TX_ERR_EN` defined: in DATA with `enable`=1 and `err`=1, emit H instead of the data group; `transmitting` stays 1.
- Undefined: `err` ignored everywhere; DATA always emits the data encoding; `err` port remains present, unused.

## Test plan
- Reset, `ce` every 5 clocks, `enable`=0, link up → `code`=11111 every pulse, `transmitting`=0, `code_ce` one clock after each `ce`.
- Packet: `enable`=1 with nibbles 5,5,5,D,0,F then `enable`=0 → J,K,01011,11011,11110,11101,T,R,I; `transmitting` high J through R.
- `PCS_TX_ERR_EN`: `err`=1 on nibble 3 of data → 00100 in that slot, others unchanged; without macro → 10101.
- `link_status` falls during DATA → next group 11111, `transmitting`=0, no T/R; link rises with `enable`=1 → J then K.
- `enable` re-asserted on the `ce` that emits R → R, then J, K, data.
- `rst_n` low mid-packet for one clock → `code`=11111, `transmitting`=0 next clock; `ce` every clock → one group per clock.
